// File: rtl/divisor_restas_4bit.sv
// 4-bit unsigned divider using repeated subtraction.
// A single restador_4bit subtracts the latched divisor from the running
// remainder once per cycle until the remainder drops below the divisor.

// Adder/subtractor: Sel=1 computes A-B in two's complement, Co=1 means no borrow.
module restador_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Sel,
  output logic [3:0] salida,
  output logic       Co
);

  logic [3:0] bMod;

  // Invert B and inject a carry-in when subtracting.
  always_comb begin
    bMod = B ^ {4{Sel}};
    {Co, salida} = {1'b0, A} + {1'b0, bMod} + {4'b0000, Sel};
  end

endmodule

module divisor_restas_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [3:0] cociente,
  output logic [3:0] resto,
  output logic       div_cero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cociente_q, cociente_d;
  logic [3:0] resto_q, resto_d;
  logic [3:0] divisor_q, divisor_d;
  logic       divCero_q, divCero_d;

  logic [3:0] subSalida;
  logic       subCo;

  // The remainder register minus the latched divisor; only used in SUB.
  restador_4bit uRestador (
    .A      (resto_q),
    .B      (divisor_q),
    .Sel    (1'b1),
    .salida (subSalida),
    .Co     (subCo)
  );

  // State and datapath registers; reset wins over everything, including a running division.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cociente_q <= 4'd0;
      resto_q    <= 4'd0;
      divisor_q  <= 4'd0;
      divCero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      divisor_q  <= divisor_d;
      divCero_q  <= divCero_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state says otherwise.
  always_comb begin
    state_d    = state_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    divisor_d  = divisor_q;
    divCero_d  = divCero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SUB;
          resto_d    = A;
          divisor_d  = B;
          cociente_d = 4'd0;
          divCero_d  = 1'b0;
        end
      end
      SUB: begin
        if (divisor_q == 4'd0) begin
          state_d    = DONE;
          divCero_d  = 1'b1;
          cociente_d = 4'hF;
        end else if (subCo) begin
          resto_d    = subSalida;
          cociente_d = cociente_q + 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags come straight from the state register, results from their registers.
  always_comb begin
    busy     = (state_q == SUB);
    done     = (state_q == DONE);
    cociente = cociente_q;
    resto    = resto_q;
    div_cero = divCero_q;
  end

endmodule

// File: tb/tb_divisor_restas_4bit.sv
// Scoreboard bench for divisor_restas_4bit: stimulus pushes the expected
// result, a monitor pops it whenever done pulses.

module tb_divisor_restas_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] cociente;
  logic [3:0] resto;
  logic       div_cero;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    int         doneCyc;
    int         busyCyc;
  } exp_t;

  exp_t sb[$];
  exp_t lastExp;
  int   errors = 0;
  int   checks = 0;
  int   cycleCnt = 0;
  int   busyCnt = 0;

  divisor_restas_4bit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .cociente (cociente),
    .resto    (resto),
    .div_cero (div_cero)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time the done pulse
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks each done pulse against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busyCnt = 0;
    end else begin
      if (busy) busyCnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("cociente", int'(cociente), int'(e.q));
          checkOutput("resto", int'(resto), int'(e.r));
          checkOutput("div_cero", int'(div_cero), int'(e.z));
          checkOutput("done_cycle", cycleCnt, e.doneCyc);
          checkOutput("busy_cycles", busyCnt, e.busyCyc);
          checkOutput("busy_with_done", int'(busy), 0);
        end
        busyCnt = 0;
      end
    end
  end

  // Issue one division: push expected, pulse start, then scramble A/B
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] expQ, input logic [3:0] expR,
                               input logic expZ);
    exp_t e;
    @(negedge clk);
    e.q = expQ;
    e.r = expR;
    e.z = expZ;
    e.busyCyc = expZ ? 1 : int'(expQ) + 1;
    e.doneCyc = cycleCnt + 1 + e.busyCyc;
    sb.push_back(e);
    lastExp = e;
    start = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    A = ~a;
    B = b + 4'd5;
  endtask

  // Wait for the scoreboard to drain, bounded
  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout_waiting_done", n, 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Results must hold while idle
  task automatic checkHold(input string tag);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_hold_q"}, int'(cociente), int'(lastExp.q));
    checkOutput({tag, "_hold_r"}, int'(resto), int'(lastExp.r));
    checkOutput({tag, "_hold_z"}, int'(div_cero), int'(lastExp.z));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_q", int'(cociente), 0);
    checkOutput("reset_r", int'(resto), 0);
    checkOutput("reset_z", int'(div_cero), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    applyStimulus(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    waitIdle();
    checkHold("d13_4");
    applyStimulus(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    waitIdle();
    applyStimulus(4'd3, 4'd7, 4'd0, 4'd3, 1'b0);
    waitIdle();
    applyStimulus(4'd9, 4'd0, 4'hF, 4'd9, 1'b1);
    waitIdle();
    checkHold("d9_0");
    applyStimulus(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
    waitIdle();
    applyStimulus(4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    waitIdle();

    // Reset mid-division: no done pulse may follow
    @(negedge clk);
    start = 1'b1;
    A = 4'd15;
    B = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_q", int'(cociente), 0);
    checkOutput("abort_r", int'(resto), 0);
    checkOutput("abort_z", int'(div_cero), 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("abort_idle_busy", int'(busy), 0);

    // First start after reset, then a start during busy that must be ignored
    applyStimulus(4'd12, 4'd3, 4'd4, 4'd0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    A = 4'd1;
    B = 4'd1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    repeat (10) @(negedge clk);
    checkHold("d12_3");

    // Full sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          applyStimulus(4'(a), 4'(b), 4'hF, 4'(a), 1'b1);
        else
          applyStimulus(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
        waitIdle();
      end
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divisor_restas_4bit.md
DIVISOR_RESTAS_4BIT -- requirements
Module: divisor_restas_4bit

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 A  input  4  dividend (unsigned); sampled with start.
REQ-006 B  input  4  divisor (unsigned); sampled with start.
REQ-007 busy  output  1  high while a division is in progress (SUB state).
REQ-008 done  output  1  one-cycle pulse marking valid results (DONE state).
REQ-009 cociente  output  4  quotient, registered.
REQ-010 resto  output  4  remainder, registered.
REQ-011 div_cero  output  1  divide-by-zero flag, registered.

Function
REQ-012 The block SHALL compute A/B by repeated subtraction, using one instance of restador_4bit with Sel tied to 1.
- The subtractor's A port is driven by the internal remainder register.
- The subtractor's B port is driven by the latched divisor.
- Subtractor Co=1 means remainder >= divisor (no borrow).
REQ-013 The FSM SHALL have the states IDLE, SUB and DONE; its encoding is free.
REQ-014 IDLE, start=1: the block SHALL go to SUB on the next edge and load, on that same edge:
- resto <= A;
- divisor register <= B;
- cociente <= 0;
- div_cero <= 0.
REQ-015 IDLE, start=0: the block SHALL stay in IDLE and hold all outputs.
REQ-016 SUB, divisor register = 0: the block SHALL go to DONE and set div_cero=1 and cociente=4'hF; resto is unchanged, so it holds A.
REQ-017 SUB, divisor nonzero, Co=1: the block SHALL set resto <= subtractor salida and cociente <= cociente+1, and stay in SUB.
REQ-018 SUB, divisor nonzero, Co=0: the block SHALL go to DONE with cociente and resto unchanged.
REQ-019 DONE: done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-020 Outputs: busy SHALL be 1 only in SUB, and done SHALL be 1 only in DONE; both SHALL be decoded from state without glitch-dependent logic.
REQ-021 Latency: with q = A/B, done SHALL be high in cycle q+2 after the edge that samples start.
- Divide-by-zero case: cycle 2.
- Worst case, A=15, B=1: cycle 17.
REQ-022 Quotient width: no quotient overflow is possible (q <= 15), and cociente SHALL never wrap.
REQ-023 start asserted while in SUB or DONE SHALL be ignored, with no effect on operands, results or state.
REQ-024 Changes on A/B after the start sample SHALL NOT affect the running division.
REQ-025 cociente, resto and div_cero SHALL hold their final values from DONE until the next accepted start.
REQ-026 A=0 with nonzero B SHALL give cociente=0, resto=0, and a latency of 2.

Reset
REQ-027 rst=1 at any edge SHALL force the FSM to IDLE and set busy=0, done=0, cociente=0, resto=0 and div_cero=0.
REQ-028 Reset SHALL take priority over start and over any in-progress division, including mid-SUB; the aborted division SHALL produce no done pulse.
REQ-029 The first start accepted after rst deasserts SHALL behave identically to the first start after power-up reset.

Verification
REQ-030 A=13, B=4, start pulse -> busy for 4 cycles, then done in cycle 5 with cociente=3, resto=1, div_cero=0.
REQ-031 A=15, B=1 -> done in cycle 17 with cociente=15, resto=0; A=3, B=7 -> done in cycle 2 with cociente=0, resto=3.
REQ-032 A=9, B=0 -> done in cycle 2 with div_cero=1, cociente=4'hF, resto=9; the next start with A=8, B=2 clears div_cero and gives cociente=4, resto=0.
REQ-033 Start A=15, B=1, assert rst for one cycle at cycle 6 -> all outputs 0 and IDLE on the next edge; no done pulse.
REQ-034 Start A=12, B=3, pulse start again with A=1, B=1 during busy -> the second start is ignored; result cociente=4, resto=0, with exactly one done pulse.
REQ-035 Exhaustive sweep, all A, B in 0..15 -> for B != 0, cociente=A/B and resto=A%B with latency q+2; for B=0, div_cero=1.
